// File: rtl/instr_fetch_reg.sv
// Multicycle instruction fetch stage: owns the PC, issues one memory read per
// fetch_start, and latches the returned word into the IR with decoded fields.
module instr_fetch_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        ir_valid,
  output logic        fetch_err,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm_16,
  output logic [25:0] target_26
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  // Abort fires on the MAX_WAIT-th unacknowledged REQ cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc, ir, addr_q;
  logic        ir_vld_q, err_q;
  logic [7:0]  wait_cnt;
  logic        start, ack_hit, tmo;

  assign start   = (state == IDLE) && fetch_start;
  assign ack_hit = (state == REQ) && mem_ack;
  assign tmo     = (state == REQ) && !mem_ack && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_start)      state_nxt = REQ;
      REQ:     if (mem_ack || tmo)   state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Request and busy are both the registered REQ state, so reset drops them at once.
  always_comb begin
    mem_req = (state == REQ);
    busy    = (state == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= '0;
      addr_q   <= '0;
      ir_vld_q <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (start) begin
        addr_q   <= pc;
        ir_vld_q <= 1'b0;
        err_q    <= 1'b0;
        wait_cnt <= '0;
      end
      if (ack_hit) begin
        ir       <= mem_rdata;
        ir_vld_q <= 1'b1;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (tmo) err_q <= 1'b1;
      end
      // A branch/jump load overrides the sequential PC+4 of a completing fetch.
      if (pc_load)      pc <= pc_next & 32'hFFFF_FFFC;
      else if (ack_hit) pc <= addr_q + 32'd4;
    end
  end

  assign mem_addr  = addr_q;
  assign ir_valid  = ir_vld_q;
  assign fetch_err = err_q;
  assign pc_out    = pc;
  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign imm_16    = ir[15:0];
  assign target_26 = ir[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Randomized bench for instr_fetch_reg against a transaction-level fetch model.
module tb_instr_fetch_reg;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int MW = 15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fetch_start = 0, pc_load = 0, mem_ack = 0;
  logic [31:0] pc_next = '0, mem_rdata = '0;
  logic        mem_req, busy, ir_valid, fetch_err;
  logic [31:0] mem_addr, pc_out;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm_16;
  logic [25:0] target_26;

  instr_fetch_reg #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .ir_valid(ir_valid), .fetch_err(fetch_err),
    .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm_16(imm_16),
    .target_26(target_26)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference: an outstanding fetch is a (address, age) pair; the PC and IR
  // follow the completion/abort rules directly.
  logic [31:0] m_pc, m_ir, m_addr;
  logic        m_vld, m_err, m_pend;
  int          m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ir = '0; m_addr = '0;
    m_vld = 0; m_err = 0; m_pend = 0; m_age = 0;
  endtask

  task automatic model_cycle(input logic fs, pl, input logic [31:0] pn, input logic ack,
                             input logic [31:0] rdat);
    logic [31:0] pc_n;
    pc_n = m_pc;
    if (m_pend) begin
      if (ack) begin
        m_ir = rdat; m_vld = 1; m_pend = 0; pc_n = m_addr + 32'd4;
      end else begin
        m_age = m_age + 1;
        if (m_age >= MW) begin m_pend = 0; m_err = 1; end
      end
    end else if (fs) begin
      m_addr = m_pc; m_pend = 1; m_vld = 0; m_err = 0; m_age = 0;
    end
    if (pl) pc_n = {pn[31:2], 2'b00};
    m_pc = pc_n;
  endtask

  task automatic check_all();
    chk("mem_req",   {31'd0, mem_req},   {31'd0, m_pend});
    chk("busy",      {31'd0, busy},      {31'd0, m_pend});
    chk("ir_valid",  {31'd0, ir_valid},  {31'd0, m_vld});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    chk("pc_out",    pc_out, m_pc);
    if (m_pend) chk("mem_addr", mem_addr, m_addr);
    chk("opcode",    {26'd0, opcode},    {26'd0, m_ir[31:26]});
    chk("rs",        {27'd0, rs},        {27'd0, m_ir[25:21]});
    chk("rt",        {27'd0, rt},        {27'd0, m_ir[20:16]});
    chk("rd",        {27'd0, rd},        {27'd0, m_ir[15:11]});
    chk("imm_16",    {16'd0, imm_16},    {16'd0, m_ir[15:0]});
    chk("target_26", {6'd0, target_26},  {6'd0, m_ir[25:0]});
  endtask

  // Drive one cycle of inputs, clock it, check 1 time unit after the edge.
  task automatic step(input logic fs, pl, input logic [31:0] pn, input logic ack,
                      input logic [31:0] rdat);
    fetch_start = fs; pc_load = pl; pc_next = pn; mem_ack = ack; mem_rdata = rdat;
    model_cycle(fs, pl, pn, ack, rdat);
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    int req_hi;
    int ack_pct;
    model_reset();
    // Reset state
    #12;
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_outs", {28'd0, mem_req, busy, ir_valid, fetch_err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_ir", {6'd0, target_26}, 32'd0);
    @(negedge clk); rst_n = 1;

    // First fetch, minimum latency
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h3C01_ABCD);
    chk("lui_vld", {31'd0, ir_valid}, 32'd1);
    chk("lui_op",  {26'd0, opcode}, 32'h0F);
    chk("lui_rt",  {27'd0, rt}, 32'd1);
    chk("lui_imm", {16'd0, imm_16}, 32'hABCD);
    chk("lui_pc",  pc_out, 32'd4);

    // Wait states with a stray fetch_start mid-REQ
    req_hi = 0;
    step(1, 0, 0, 0, 0);                req_hi += int'(mem_req);
    step(0, 0, 0, 0, 0);                req_hi += int'(mem_req);
    step(1, 0, 0, 0, 0);                req_hi += int'(mem_req);
    step(0, 0, 0, 0, 0);                req_hi += int'(mem_req);
    step(0, 0, 0, 1, $urandom());       req_hi += int'(mem_req);
    chk("req_cycles", 32'(req_hi), 32'd4);
    step(0, 0, 0, 0, 0);
    chk("no_2nd_req", {31'd0, mem_req}, 32'd0);

    // PC forcing and wrap
    step(0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("pc_force", pc_out, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h1234_5678);
    chk("pc_wrap", pc_out, 32'd0);

    // pc_load in the ack cycle beats PC+4
    step(0, 1, 32'h40, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h100, 1, 32'h8C22_0010);
    chk("ld_ack_pc", pc_out, 32'h100);
    chk("ld_ack_ir", {16'd0, imm_16}, 32'h0010);

    // Timeout
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < MW; i++) step(0, 0, 0, 0, 0);
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_vld", {31'd0, ir_valid}, 32'd0);
    chk("tmo_pc",  pc_out, 32'h100);
    step(1, 0, 0, 0, 0);
    chk("tmo_clr", {31'd0, fetch_err}, 32'd0);
    step(0, 0, 0, 1, 32'h0000_0020);

    // Asynchronous reset while a request is outstanding
    step(1, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1 chk("arst_req", {31'd0, mem_req}, 32'd0);
    model_reset();
    #1 rst_n = 1;
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("late_ack", {31'd0, ir_valid}, 32'd0);

    // Randomized traffic with varying memory responsiveness
    ack_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ack_pct = (n % 600 == 0) ? 3 : ((n % 400 == 0) ? 30 : 85);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom(),
           $urandom_range(0, 99) < ack_pct, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch_reg.md
# instr_fetch_reg

Multicycle fetch stage. Holds the PC, issues one instruction-memory read per `fetch_start`, and latches the returned word into the instruction register (IR). Exposes the decoded IR fields (opcode, rs, rt, rd, imm_16, target_26) to the decode/execute datapath. `imm_16` is the direct source for the zero- and sign-extension units.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset. Bits [1:0] must be 0.
- `MAX_WAIT`, 15: maximum number of REQ-state cycles without `mem_ack` before the fetch is aborted. Range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_start`  in  1  one-cycle request from the control FSM to fetch at the current PC.
- `pc_load`  in  1  load PC from `pc_next` (branch/jump).
- `pc_next`  in  32  new PC value; bits [1:0] are ignored and forced to 0.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  32  read address, stable while `mem_req` is high.
- `mem_ack`  in  1  memory has valid `mem_rdata` this cycle.
- `mem_rdata`  in  32  instruction word.
- `busy`  out  1  high while in REQ.
- `ir_valid`  out  1  IR holds a completed fetch.
- `fetch_err`  out  1  last fetch timed out; sticky until the next accepted `fetch_start`.
- `pc_out`  out  32  current PC.
- `opcode`  out  6  IR[31:26].
- `rs`  out  5  IR[25:21].
- `rt`  out  5  IR[20:16].
- `rd`  out  5  IR[15:11].
- `imm_16`  out  16  IR[15:0].
- `target_26`  out  26  IR[25:0].

## Operation
- State machine has 2 states: IDLE and REQ.
- **Reset** (`rst_n`=0, asynchronous):
  - state = IDLE; PC = `RESET_PC`; IR = 0.
  - `mem_req`=0, `mem_addr`=0, `busy`=0, `ir_valid`=0, `fetch_err`=0, wait counter = 0.
- **IDLE, `fetch_start`=1:**
  - `mem_addr` <= PC; `mem_req` <= 1; `ir_valid` <= 0; `fetch_err` <= 0; wait counter <= 0.
  - Next state REQ.
- **REQ, `mem_ack`=1:**
  - IR <= `mem_rdata`; `ir_valid` <= 1; `mem_req` <= 0.
  - PC <= `mem_addr` + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Next state IDLE.
- **REQ, `mem_ack`=0:**
  - Wait counter increments.
  - When the counter reaches `MAX_WAIT`: `mem_req` <= 0; `fetch_err` <= 1; IR, PC and `ir_valid` (=0) are unchanged; next state IDLE.
- **`fetch_start` in REQ:** ignored; no queuing.
- **`pc_load`:** accepted in any state; PC <= {`pc_next`[31:2], 2'b00}.
  - Same cycle as an ack: `pc_load` wins over PC+4. IR is still latched.
  - During REQ: `mem_addr` does not change; the in-flight fetch completes from the old address.
- **`pc_load` and `fetch_start` in the same IDLE cycle:** `mem_addr` uses the old PC; PC takes `pc_next`.
- **`mem_ack` outside REQ:** ignored.
- **Field outputs:** combinational slices of IR; they change only when IR is written.

## Timing
- `fetch_start` sampled at edge N: `mem_req`/`mem_addr` are valid from N+1.
- `mem_ack` sampled at edge M: IR, fields and `ir_valid` are valid from M+1, and `mem_req` drops at M+1.
- Minimum latency from `fetch_start` to `ir_valid` is 2 edges, with `mem_ack` high in the first REQ cycle.
- `busy` equals (state==REQ) and is registered.
- Timeout: `fetch_err` rises `MAX_WAIT` edges after `mem_req` rose.
- Reset mid-REQ: `mem_req` drops immediately (asynchronously), and any ack on later cycles is discarded.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs 0 and `pc_out`=`RESET_PC`. Release, then `fetch_start` with `mem_ack` the next cycle and `mem_rdata`=32'h3C01_ABCD → `ir_valid`=1, `opcode`=6'h0F, `rt`=1, `imm_16`=16'hABCD, `pc_out`=4.
- **Wait states:** `fetch_start`, then `mem_ack` after 3 idle cycles → `mem_req` high exactly 4 cycles and `mem_addr` stable. Issue a second `fetch_start` mid-REQ → no second request.
- **Wrap and forcing:** `pc_load` with `pc_next`=32'hFFFF_FFFF → `pc_out`=32'hFFFF_FFFC. Then fetch → `pc_out`=0.
- **Load vs. ack:** `pc_load` (`pc_next`=32'h100) in the ack cycle of a fetch from 32'h40 → IR latched and `pc_out`=32'h100, not 32'h44.
- **Timeout:** `MAX_WAIT`=15 with no ack → `fetch_err`=1 after 15 cycles, `ir_valid`=0, PC unchanged. The next `fetch_start` clears `fetch_err`.
- **Async reset mid-REQ:** pulse `rst_n` low between clock edges while in REQ → `mem_req` falls immediately. A late ack → no IR update.
